// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared types and constants for the two-slot TDM word receiver.
//   tdm_rx_state_t : receiver FSM states (WAIT_A, WAIT_B)
//   SLOT_A/SLOT_B  : tdm_sel encodings for the two slots
//   TDM_DATA_W     : default width of each BRx register
// ---------------------------------------------------------------------------
package tdm_pkg;

  typedef enum logic {WAIT_A, WAIT_B} tdm_rx_state_t;

  localparam logic SLOT_A     = 1'b0;
  localparam logic SLOT_B     = 1'b1;
  localparam int   TDM_DATA_W = 16;

endpackage : tdm_pkg

// File: rtl/tdm_to_reg_if.sv
// ---------------------------------------------------------------------------
// tdm_to_reg_if
// Word link from the TDM packer to the receiver.
//   tdm_in    : 2*DATA_W word (slot A = {BR1,BR2}, slot B = {pad,BR3})
//   tdm_sel   : slot of tdm_in, 0 = A, 1 = B
//   tdm_valid : tdm_in/tdm_sel carry a word this cycle
// Modports: master drives the link, slave receives it.
// ---------------------------------------------------------------------------
interface tdm_to_reg_if
  import tdm_pkg::*;
#(
  parameter int DATA_W = TDM_DATA_W
) ();

  logic [2*DATA_W-1:0] tdm_in;
  logic                tdm_sel;
  logic                tdm_valid;

  modport master (output tdm_in, output tdm_sel, output tdm_valid);
  modport slave  (input  tdm_in, input  tdm_sel, input  tdm_valid);

endinterface : tdm_to_reg_if

// File: rtl/tdm_rx_fsm.sv
// ---------------------------------------------------------------------------
// tdm_rx_fsm
// Slot-order tracker for the TDM receiver: state register plus decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (state -> WAIT_A)
//   clr        : synchronous resync, forces WAIT_A and masks the word
//   valid, sel : word strobe and its slot
//   pad_ok     : slot B word is acceptable for commit
//   load_sh    : load shadow registers from the current slot A word
//   commit     : transfer shadows + BR3 into the output registers
//   err        : protocol error on the current word
// load_sh/commit/err are combinational decodes of the current word.
// ---------------------------------------------------------------------------
module tdm_rx_fsm
  import tdm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic valid,
  input  logic sel,
  input  logic pad_ok,
  output logic load_sh,
  output logic commit,
  output logic err
);

  tdm_rx_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_sh = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    // clr wins over a same-cycle word; that word vanishes silently.
    if (clr) begin
      state_d = WAIT_A;
    end else if (valid) begin
      case (state_q)
        WAIT_A: begin
          if (sel == SLOT_A) begin
            load_sh = 1'b1;
            state_d = WAIT_B;
          end else begin
            err = 1'b1;
          end
        end
        WAIT_B: begin
          if (sel == SLOT_A) begin
            // Repeated A: treat the newest A as the start of the frame.
            load_sh = 1'b1;
            err     = 1'b1;
          end else begin
            state_d = WAIT_A;
            if (pad_ok) commit = 1'b1;
            else        err    = 1'b1;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

endmodule : tdm_rx_fsm

// File: rtl/tdm_to_reg.sv
// ---------------------------------------------------------------------------
// tdm_to_reg
// Receive end of the two-slot TDM word link. Rebuilds BR1/BR2/BR3 from a
// slot A word {BR1,BR2} followed by a slot B word {pad,BR3}; all three
// registers commit together on the edge that samples the B word.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (everything -> 0)
//   clr          : synchronous resync; drops partial frame, keeps outputs
//   link         : tdm_to_reg_if.slave (tdm_in, tdm_sel, tdm_valid)
//   br1_o..br3_o : last committed register values
//   frame_done   : 1-cycle pulse per committed frame
//   slot_err     : 1-cycle pulse per protocol error
//   frame_cnt    : committed frames, mod 2**FCNT_W
// Configuration macro: TDM_PAD_CHECK_EN -- when defined, a slot B word with
// nonzero upper half is rejected (slot_err, no commit, back to WAIT_A);
// when undefined the upper half of a B word is ignored.
// ---------------------------------------------------------------------------
module tdm_to_reg
  import tdm_pkg::*;
#(
  parameter int DATA_W = TDM_DATA_W,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  tdm_to_reg_if.slave       link,
  output logic [DATA_W-1:0] br1_o,
  output logic [DATA_W-1:0] br2_o,
  output logic [DATA_W-1:0] br3_o,
  output logic              frame_done,
  output logic              slot_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic load_sh, commit, err, pad_ok;

`ifdef TDM_PAD_CHECK_EN
  assign pad_ok = (link.tdm_in[2*DATA_W-1:DATA_W] == '0);
`else
  assign pad_ok = 1'b1;
`endif

  tdm_rx_fsm u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .valid   (link.tdm_valid),
    .sel     (link.tdm_sel),
    .pad_ok  (pad_ok),
    .load_sh (load_sh),
    .commit  (commit),
    .err     (err)
  );

  logic [DATA_W-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [DATA_W-1:0] br1_q, br1_d, br2_q, br2_d, br3_q, br3_d;
  logic              frame_done_q, frame_done_d;
  logic              slot_err_q, slot_err_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    sh1_d        = sh1_q;
    sh2_d        = sh2_q;
    br1_d        = br1_q;
    br2_d        = br2_q;
    br3_d        = br3_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = commit;
    slot_err_d   = err;

    if (clr) begin
      sh1_d = '0;
      sh2_d = '0;
    end else if (load_sh) begin
      sh1_d = link.tdm_in[2*DATA_W-1:DATA_W];
      sh2_d = link.tdm_in[DATA_W-1:0];
    end

    // Whole-frame update: the three outputs never change separately.
    if (commit) begin
      br1_d       = sh1_q;
      br2_d       = sh2_q;
      br3_d       = link.tdm_in[DATA_W-1:0];
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh1_q        <= '0;
      sh2_q        <= '0;
      br1_q        <= '0;
      br2_q        <= '0;
      br3_q        <= '0;
      frame_done_q <= 1'b0;
      slot_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      sh1_q        <= sh1_d;
      sh2_q        <= sh2_d;
      br1_q        <= br1_d;
      br2_q        <= br2_d;
      br3_q        <= br3_d;
      frame_done_q <= frame_done_d;
      slot_err_q   <= slot_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign br1_o      = br1_q;
  assign br2_o      = br2_q;
  assign br3_o      = br3_q;
  assign frame_done = frame_done_q;
  assign slot_err   = slot_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule : tdm_to_reg

// File: tb/tb_tdm_to_reg.sv
// ---------------------------------------------------------------------------
// tb_tdm_to_reg
// Directed and randomized stimulus for tdm_to_reg, checked after every clock
// against a frame-level reference model (pending A word + committed values).
// ---------------------------------------------------------------------------
module tb_tdm_to_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [15:0] br1_o, br2_o, br3_o;
  logic        frame_done, slot_err;
  logic [7:0]  frame_cnt;

  tdm_to_reg_if #(.DATA_W(16)) link ();

  tdm_to_reg #(.DATA_W(16), .FCNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .link       (link),
    .br1_o      (br1_o),
    .br2_o      (br2_o),
    .br3_o      (br3_o),
    .frame_done (frame_done),
    .slot_err   (slot_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is "pending A" + "B"; outputs are last frame.
  bit          have_a;
  logic [31:0] a_word;
  logic [15:0] e_br1, e_br2, e_br3;
  logic        e_done, e_err;
  int          e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".br1"},  {16'h0, br1_o}, {16'h0, e_br1});
    chk({tag, ".br2"},  {16'h0, br2_o}, {16'h0, e_br2});
    chk({tag, ".br3"},  {16'h0, br3_o}, {16'h0, e_br3});
    chk({tag, ".done"}, {31'h0, frame_done}, {31'h0, e_done});
    chk({tag, ".err"},  {31'h0, slot_err},   {31'h0, e_err});
    chk({tag, ".cnt"},  {24'h0, frame_cnt},  e_cnt[31:0]);
  endtask

  task automatic model_reset();
    have_a = 1'b0; a_word = '0;
    e_br1 = '0; e_br2 = '0; e_br3 = '0;
    e_done = 1'b0; e_err = 1'b0; e_cnt = 0;
  endtask

  task automatic model_word(input bit v, input bit s, input logic [31:0] w, input bit c);
    bit pad_bad;
`ifdef TDM_PAD_CHECK_EN
    pad_bad = (w[31:16] != 16'h0);
`else
    pad_bad = 1'b0;
`endif
    e_done = 1'b0;
    e_err  = 1'b0;
    if (c) begin
      have_a = 1'b0;
    end else if (v) begin
      if (s == 1'b0) begin
        if (have_a) e_err = 1'b1;
        a_word = w;
        have_a = 1'b1;
      end else if (!have_a) begin
        e_err = 1'b1;
      end else if (pad_bad) begin
        e_err  = 1'b1;
        have_a = 1'b0;
      end else begin
        e_br1  = a_word[31:16];
        e_br2  = a_word[15:0];
        e_br3  = w[15:0];
        e_cnt  = (e_cnt + 1) % 256;
        e_done = 1'b1;
        have_a = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag, input bit v, input bit s,
                      input logic [31:0] w, input bit c);
    @(negedge clk);
    link.tdm_valid = v;
    link.tdm_sel   = s;
    link.tdm_in    = w;
    clr            = c;
    @(posedge clk);
    #1;
    model_word(v, s, w, c);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    bit          v, s, c;

    rst_n = 1'b1; clr = 1'b0;
    link.tdm_valid = 1'b0; link.tdm_sel = 1'b0; link.tdm_in = '0;
    model_reset();
    #3 rst_n = 1'b0;
    #1 check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Basic frame on consecutive cycles.
    step("a1",   1'b1, 1'b0, 32'h1234_5678, 1'b0);
    step("b1",   1'b1, 1'b1, 32'h0000_9ABC, 1'b0);
    idle("post1");

    // Gap between A and B.
    step("a2",   1'b1, 1'b0, 32'hAAAA_BBBB, 1'b0);
    idle("gap0"); idle("gap1"); idle("gap2");
    step("b2",   1'b1, 1'b1, 32'h0000_CCCC, 1'b0);
    idle("post2");

    // Orphan B, then repeated A resync.
    step("orphB", 1'b1, 1'b1, 32'h0000_1111, 1'b0);
    step("a3",    1'b1, 1'b0, 32'h0001_0002, 1'b0);
    step("a3dup", 1'b1, 1'b0, 32'h0003_0004, 1'b0);
    step("b3",    1'b1, 1'b1, 32'h0000_0005, 1'b0);
    idle("post3");

    // clr with a same-cycle B: dropped, then FSM must be in WAIT_A.
    step("a4",    1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    step("clrB",  1'b1, 1'b1, 32'h0000_0001, 1'b1);
    step("afterclr", 1'b1, 1'b1, 32'h0000_0002, 1'b0);

    // Nonzero pad in a B word.
    step("a5",    1'b1, 1'b0, 32'h4444_5555, 1'b0);
    step("bpad",  1'b1, 1'b1, 32'h0001_0007, 1'b0);
    idle("post5");

    // Asynchronous reset mid-frame.
    step("a6",    1'b1, 1'b0, 32'h7777_8888, 1'b0);
    @(negedge clk);
    link.tdm_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("midrst");
    @(negedge clk) rst_n = 1'b1;
    step("bnoA",  1'b1, 1'b1, 32'h0000_9999, 1'b0);

    // 256 back-to-back frames: counter wraps back to 0.
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      step("wrapA", 1'b1, 1'b0, w, 1'b0);
      w = $urandom & 32'h0000_FFFF;
      step("wrapB", 1'b1, 1'b1, w, 1'b0);
    end
    idle("postwrap");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, 1);
      c = ($urandom_range(0, 24) == 0);
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:16] = 16'h0;
      step("rand", v, s, w, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tdm_to_reg
